e203_exu_wbck_sched: RTL and testbench

Write-back scheduler and long-pipe scoreboard for the integer register file. Arbitrates the single-cycle ALU result and the long-pipe result (load, mul/div) onto the register file's only write port. Also tracks which destination registers still await long-pipe results, and stalls dispatch on RAW/WAW hazards against them. Sits between the dispatch/commit logic and the register-file write port.

---
 rtl/e203_exu_wbck_sched.sv | 106 ++++++++++
 tb/tb_e203_exu_wbck_sched.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/e203_exu_wbck_sched.sv
// Write-back arbiter (long pipe over ALU, zero latency) and long-pipe pending scoreboard.
// Backpressure: long pipe always accepted, ALU stalled by a long-pipe write-back, dispatch stalled on RAW/WAW/full.
module e203_exu_wbck_sched #(
    parameter int XLEN      = 32,
    parameter int RFIDX_W   = 5,
    parameter int RFREG_NUM = 32,
    parameter int MAX_OUTST = 4
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               alu_wbck_valid,
    output logic               alu_wbck_ready,
    input  logic [RFIDX_W-1:0] alu_wbck_idx,
    input  logic [XLEN-1:0]    alu_wbck_dat,

    input  logic               longp_wbck_valid,
    output logic               longp_wbck_ready,
    input  logic [RFIDX_W-1:0] longp_wbck_idx,
    input  logic [XLEN-1:0]    longp_wbck_dat,

    output logic               rf_wen,
    output logic [RFIDX_W-1:0] rf_idx,
    output logic [XLEN-1:0]    rf_dat,

    input  logic               disp_valid,
    output logic               disp_ready,
    input  logic               disp_longp,
    input  logic               disp_rs1en,
    input  logic               disp_rs2en,
    input  logic               disp_rdwen,
    input  logic [RFIDX_W-1:0] disp_rs1idx,
    input  logic [RFIDX_W-1:0] disp_rs2idx,
    input  logic [RFIDX_W-1:0] disp_rdidx,

    output logic [3:0]         pend_cnt,
    output logic               longp_empty
);

    localparam int       NIDX    = 2 ** RFIDX_W;
    localparam logic [3:0] CNT_MAX = 4'(MAX_OUTST);

    logic [RFREG_NUM-1:0] pend_q, pend_d;
    logic [3:0]           cnt_q, cnt_d;

    // Index space padded to the full index width so out-of-range indices (RV32E) read as not pending.
    logic [NIDX-1:0]      pend_ext;
    logic [NIDX-1:0]      pend_nx;

    logic raw, waw, full, disp_fire, cnt_inc, cnt_dec, pend_set;

    // Write port: long pipe wins, ALU data is the idle default.
    always_comb begin
        longp_wbck_ready = 1'b1;
        alu_wbck_ready   = ~longp_wbck_valid;
        rf_idx           = alu_wbck_idx;
        rf_dat           = alu_wbck_dat;
        if (longp_wbck_valid) begin
            rf_idx = longp_wbck_idx;
            rf_dat = longp_wbck_dat;
        end
        rf_wen = (longp_wbck_valid | alu_wbck_valid) & (rf_idx != '0);
    end

    always_comb begin
        pend_ext                 = '0;
        pend_ext[RFREG_NUM-1:0]  = pend_q;
        pend_ext[0]              = 1'b0;
    end

    // Hazards use registered state only; a retiring write-back is not bypassed.
    always_comb begin
        raw        = (disp_rs1en & pend_ext[disp_rs1idx]) | (disp_rs2en & pend_ext[disp_rs2idx]);
        waw        = disp_rdwen & pend_ext[disp_rdidx];
        full       = disp_longp & (cnt_q == CNT_MAX);
        disp_ready = ~raw & ~waw & ~full;
        disp_fire  = disp_valid & disp_ready;
    end

    always_comb begin
        cnt_inc  = disp_fire & disp_longp;
        cnt_dec  = longp_wbck_valid & (cnt_q != 4'd0);
        pend_set = cnt_inc & disp_rdwen & (disp_rdidx != '0);
        cnt_d    = cnt_q + {3'b000, cnt_inc} - {3'b000, cnt_dec};

        pend_nx = pend_ext;
        if (longp_wbck_valid) pend_nx[longp_wbck_idx] = 1'b0;
        if (pend_set)         pend_nx[disp_rdidx]     = 1'b1;
        pend_nx[0] = 1'b0;
        pend_d     = pend_nx[RFREG_NUM-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
            cnt_q  <= 4'd0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pend_cnt    = cnt_q;
    assign longp_empty = (cnt_q == 4'd0);

endmodule

// File: tb/tb_e203_exu_wbck_sched.sv
// Directed bench: register-file writes checked by a scoreboard monitor, scoreboard state checked inline.
module tb_e203_exu_wbck_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_wbck_valid = 0, longp_wbck_valid = 0;
    logic        alu_wbck_ready, longp_wbck_ready;
    logic [4:0]  alu_wbck_idx = 0, longp_wbck_idx = 0;
    logic [31:0] alu_wbck_dat = 0, longp_wbck_dat = 0;
    logic        rf_wen;
    logic [4:0]  rf_idx;
    logic [31:0] rf_dat;
    logic        disp_valid = 0, disp_ready, disp_longp = 0;
    logic        disp_rs1en = 0, disp_rs2en = 0, disp_rdwen = 0;
    logic [4:0]  disp_rs1idx = 0, disp_rs2idx = 0, disp_rdidx = 0;
    logic [3:0]  pend_cnt;
    logic        longp_empty;

    int n_chk = 0;
    int n_fail = 0;
    logic [36:0] exp_q[$];

    always #5 clk = ~clk;

    e203_exu_wbck_sched dut (
        .clk(clk), .rst(rst),
        .alu_wbck_valid(alu_wbck_valid), .alu_wbck_ready(alu_wbck_ready),
        .alu_wbck_idx(alu_wbck_idx), .alu_wbck_dat(alu_wbck_dat),
        .longp_wbck_valid(longp_wbck_valid), .longp_wbck_ready(longp_wbck_ready),
        .longp_wbck_idx(longp_wbck_idx), .longp_wbck_dat(longp_wbck_dat),
        .rf_wen(rf_wen), .rf_idx(rf_idx), .rf_dat(rf_dat),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_longp(disp_longp),
        .disp_rs1en(disp_rs1en), .disp_rs2en(disp_rs2en), .disp_rdwen(disp_rdwen),
        .disp_rs1idx(disp_rs1idx), .disp_rs2idx(disp_rs2idx), .disp_rdidx(disp_rdidx),
        .pend_cnt(pend_cnt), .longp_empty(longp_empty)
    );

    // Monitor: every register-file write must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && rf_wen) begin
            logic [36:0] e;
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rf_write: unexpected write idx=%0d dat=%h, none expected", rf_idx, rf_dat);
            end else begin
                e = exp_q.pop_front();
                if ({rf_idx, rf_dat} !== e) begin
                    n_fail++;
                    $display("FAIL rf_write: got idx=%0d dat=%h, expected idx=%0d dat=%h",
                             rf_idx, rf_dat, e[36:32], e[31:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic v, input logic lp, input logic r1e, input logic [4:0] r1,
                        input logic r2e, input logic [4:0] r2, input logic rde, input logic [4:0] rd);
        disp_valid = v; disp_longp = lp;
        disp_rs1en = r1e; disp_rs1idx = r1;
        disp_rs2en = r2e; disp_rs2idx = r2;
        disp_rdwen = rde; disp_rdidx = rd;
    endtask

    task automatic retire(input logic v, input logic [4:0] idx, input logic [31:0] dat);
        longp_wbck_valid = v; longp_wbck_idx = idx; longp_wbck_dat = dat;
        if (v && idx != 0) exp_q.push_back({idx, dat});
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_cnt", 32'(pend_cnt), 0);
        chk("reset_empty", 32'(longp_empty), 1);
        chk("reset_ready", 32'(disp_ready), 1);

        // Collision: long pipe wins; its retire at count 0 must saturate.
        cyc();
        alu_wbck_valid = 1; alu_wbck_idx = 5; alu_wbck_dat = 32'h11;
        retire(1, 6, 32'h22);
        @(negedge clk);
        chk("coll_alu_rdy", 32'(alu_wbck_ready), 0);
        chk("coll_lp_rdy", 32'(longp_wbck_ready), 1);
        cyc();
        retire(0, 0, 0);
        exp_q.push_back({5'd5, 32'h11});
        @(negedge clk);
        chk("alu_alone_rdy", 32'(alu_wbck_ready), 1);
        chk("underflow_sat", 32'(pend_cnt), 0);
        cyc();
        alu_wbck_valid = 0;

        // RAW on rd=7
        disp(1, 1, 0, 0, 0, 0, 1, 7);
        @(negedge clk);
        chk("raw_lp_disp", 32'(disp_ready), 1);
        cyc();
        disp(1, 0, 0, 0, 1, 7, 1, 10);
        @(negedge clk);
        chk("raw_stall0", 32'(disp_ready), 0);
        chk("raw_cnt", 32'(pend_cnt), 1);
        cyc();
        @(negedge clk);
        chk("raw_stall1", 32'(disp_ready), 0);
        cyc();
        retire(1, 7, 32'h77);
        @(negedge clk);
        chk("raw_stall_retire", 32'(disp_ready), 0);
        cyc();
        retire(0, 0, 0);
        @(negedge clk);
        chk("raw_release", 32'(disp_ready), 1);
        chk("raw_cnt_after", 32'(pend_cnt), 0);

        // WAW on rd=9
        cyc();
        disp(1, 1, 0, 0, 0, 0, 1, 9);
        cyc();
        disp(1, 0, 1, 3, 0, 0, 1, 9);
        @(negedge clk);
        chk("waw_stall", 32'(disp_ready), 0);
        cyc();
        retire(1, 9, 32'h99);
        @(negedge clk);
        chk("waw_stall_retire", 32'(disp_ready), 0);
        cyc();
        retire(0, 0, 0);
        @(negedge clk);
        chk("waw_release", 32'(disp_ready), 1);

        // x0 destination on the long pipe
        cyc();
        disp(1, 1, 0, 0, 0, 0, 1, 0);
        cyc();
        disp(1, 0, 1, 0, 1, 0, 1, 0);
        @(negedge clk);
        chk("x0_cnt", 32'(pend_cnt), 1);
        chk("x0_no_hazard", 32'(disp_ready), 1);
        cyc();
        disp(0, 0, 0, 0, 0, 0, 0, 0);
        retire(1, 0, 32'h55);
        @(negedge clk);
        chk("x0_no_wen", 32'(rf_wen), 0);
        cyc();
        retire(0, 0, 0);
        @(negedge clk);
        chk("x0_cnt_after", 32'(pend_cnt), 0);

        // Capacity
        for (int k = 1; k <= 4; k++) begin
            cyc();
            disp(1, 1, 0, 0, 0, 0, 1, 5'(k));
            @(negedge clk);
            chk("cap_fill_rdy", 32'(disp_ready), 1);
        end
        cyc();
        disp(1, 1, 0, 0, 0, 0, 1, 5);
        @(negedge clk);
        chk("cap_cnt4", 32'(pend_cnt), 4);
        chk("cap_full", 32'(disp_ready), 0);
        cyc();
        disp(1, 0, 1, 6, 0, 0, 1, 8);
        @(negedge clk);
        chk("cap_nonlp_ok", 32'(disp_ready), 1);
        cyc();
        disp(0, 0, 0, 0, 0, 0, 0, 0);
        retire(1, 1, 32'hA1);
        cyc();
        retire(1, 2, 32'hA2);
        disp(1, 1, 0, 0, 0, 0, 1, 5);
        @(negedge clk);
        chk("cap_cnt3", 32'(pend_cnt), 3);
        chk("cap_redisp_rdy", 32'(disp_ready), 1);
        cyc();
        retire(0, 0, 0);
        disp(1, 1, 0, 0, 0, 0, 1, 6);
        @(negedge clk);
        chk("cap_same_cycle_cnt", 32'(pend_cnt), 3);
        cyc();
        disp(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("cap_refill", 32'(pend_cnt), 4);
        for (int k = 3; k <= 6; k++) begin
            cyc();
            retire(1, 5'(k), 32'hA0 + 32'(k));
        end
        cyc();
        retire(0, 0, 0);
        @(negedge clk);
        chk("cap_drain_cnt", 32'(pend_cnt), 0);
        chk("cap_drain_empty", 32'(longp_empty), 1);

        // Asynchronous reset mid-operation
        for (int k = 11; k <= 13; k++) begin
            cyc();
            disp(1, 1, 0, 0, 0, 0, 1, 5'(k));
        end
        cyc();
        disp(1, 1, 1, 12, 0, 0, 1, 14);
        @(negedge clk);
        chk("rst_pre_cnt", 32'(pend_cnt), 3);
        chk("rst_pre_raw", 32'(disp_ready), 0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rst_async_cnt", 32'(pend_cnt), 0);
        chk("rst_async_empty", 32'(longp_empty), 1);
        chk("rst_async_ready", 32'(disp_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_release_ready", 32'(disp_ready), 1);
        cyc();
        disp(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("post_rst_cnt", 32'(pend_cnt), 1);

        repeat (2) @(negedge clk);
        chk("writes_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
